// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multi-cycle MIPS control path.
// Holds the decoded opcode values, the controller state encoding, the
// alu_op encodings shared with alu_control, and the PC source select codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_SUB   = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // True for every opcode the controller knows how to sequence,
    // including HALT (which stops cleanly rather than flagging an error).
    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW,
            OP_BEQ, OP_J, OP_HALT: legal = 1'b1;
            default:               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: bounded wait on the memory-ready handshake.
// Ports:
//   clk, reset  - clock and asynchronous active-low reset
//   clear       - reload the countdown (any cycle that is not a pending wait)
//   tick        - a wait cycle in which memory did not respond
//   expire      - this tick is the MEM_TIMEOUT-th consecutive unanswered cycle
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LOAD = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Countdown holds the number of unanswered cycles still tolerated
    // after the current one; it only moves on a tick and reloads otherwise.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = LOAD;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Expiry is qualified by tick, so a ready response on the terminal
    // cycle never raises it.
    assign expire = tick && (count_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= LOAD;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for
// the multi-cycle MIPS datapath.
// Ports:
//   clk, reset         - clock and asynchronous active-low reset
//   enable             - run permission, only looked at in FETCH
//   opcode, zero       - instruction[31:26] and ALU zero flag
//   mem_ready          - memory access complete (fetch or data)
//   pc_write, pc_src   - PC load strobe and source select
//   ir_write           - instruction register latch
//   mem_read/mem_write - memory requests, held until mem_ready
//   reg_write, reg_dst, write_data_select - register file write controls
//   alu_select, alu_op - ALU operand 2 select and ALU control code
//   halted, error      - status: stopped / sticky fault
//   instr_count        - retired instructions, wraps modulo 2^CNT_W
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             write_data_select,
    output logic             alu_select,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q;
    state_e           state_d;
    logic             error_q;
    logic             error_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic wait_active;
    logic wait_tick;
    logic wait_expire;

    // A memory wait is pending during an enabled fetch or a data access;
    // every other cycle reloads the timer so each wait starts fresh.
    assign wait_active = ((state_q == ST_FETCH) && enable) || (state_q == ST_MEMORY);
    assign wait_tick   = wait_active && !mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!wait_active),
        .tick   (wait_tick),
        .expire (wait_expire)
    );

    // Next state, status updates and the combinational strobes. The opcode
    // input comes straight from the instruction register, which stays stable
    // from DECODE until the next fetch, so it is used directly in each state.
    always_comb begin
        state_d           = state_q;
        error_d           = error_q;
        count_d           = count_q;
        pc_write          = 1'b0;
        pc_src            = PC_SRC_PLUS4;
        ir_write          = 1'b0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        reg_write         = 1'b0;
        reg_dst           = 1'b0;
        write_data_select = 1'b0;
        alu_select        = 1'b0;
        alu_op            = ALU_OP_ADD;

        case (state_q)
            ST_FETCH: begin
                if (enable) begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_PLUS4;
                        state_d  = ST_DECODE;
                    end else if (wait_expire) begin
                        state_d = ST_HALT;
                        error_d = 1'b1;
                    end
                end
            end

            ST_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (!is_legal_op(opcode)) begin
                    state_d = ST_HALT;
                    error_d = 1'b1;
                end else if (opcode == OP_J) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end

            ST_EXECUTE: begin
                case (opcode)
                    OP_RTYPE: begin
                        alu_op  = ALU_OP_FUNCT;
                        state_d = ST_WRITEBACK;
                    end
                    OP_ADDI: begin
                        alu_op     = ALU_OP_ADD;
                        alu_select = 1'b1;
                        state_d    = ST_WRITEBACK;
                    end
                    OP_LW, OP_SW: begin
                        alu_op     = ALU_OP_ADD;
                        alu_select = 1'b1;
                        state_d    = ST_MEMORY;
                    end
                    OP_BEQ: begin
                        alu_op = ALU_OP_SUB;
                        if (zero) begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_BRANCH;
                        end
                        state_d = ST_WRITEBACK;
                    end
                    default: begin
                        // Opcode changed underneath us; stop rather than guess.
                        state_d = ST_HALT;
                        error_d = 1'b1;
                    end
                endcase
            end

            ST_MEMORY: begin
                if (opcode == OP_SW) begin
                    mem_write = 1'b1;
                end else begin
                    mem_read = 1'b1;
                end
                if (mem_ready) begin
                    state_d = ST_WRITEBACK;
                end else if (wait_expire) begin
                    state_d = ST_HALT;
                    error_d = 1'b1;
                end
            end

            ST_WRITEBACK: begin
                count_d = count_q + CNT_W'(1);
                state_d = ST_FETCH;
                case (opcode)
                    OP_RTYPE: begin
                        reg_write = 1'b1;
                        reg_dst   = 1'b1;
                    end
                    OP_ADDI: begin
                        reg_write = 1'b1;
                    end
                    OP_LW: begin
                        reg_write         = 1'b1;
                        write_data_select = 1'b1;
                    end
                    OP_J: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                    end
                    default: begin
                    end
                endcase
            end

            ST_HALT: begin
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Strobes are combinational, so they must be forced low while reset
        // is asserted or a write could slip out after the reset edge.
        if (!reset) begin
            pc_write          = 1'b0;
            pc_src            = PC_SRC_PLUS4;
            ir_write          = 1'b0;
            mem_read          = 1'b0;
            mem_write         = 1'b0;
            reg_write         = 1'b0;
            reg_dst           = 1'b0;
            write_data_select = 1'b0;
            alu_select        = 1'b0;
            alu_op            = ALU_OP_ADD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    assign halted      = (state_q == ST_HALT);
    assign error       = error_q;
    assign instr_count = count_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the MIPS datapath (program counter, instruction fetch, register file, ALU, data memory port).
- Runs a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine and drives the per-cycle enables and mux selects.
- Waits on a memory-ready handshake with a bounded timeout.
- Counts retired instructions, halts on HALT or an illegal opcode, and reports status.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- MEM_TIMEOUT, 15, maximum cycles waiting for mem_ready before error (must be >=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  run permission; sampled only in FETCH
- opcode  input  6  instruction[31:26] from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access complete (fetch or data)
- pc_write  output  1  load PC this cycle
- pc_src  output  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target
- ir_write  output  1  latch instruction register
- mem_read  output  1  memory read request (held until mem_ready)
- mem_write  output  1  memory write request (held until mem_ready)
- reg_write  output  1  register file write enable
- reg_dst  output  1  write register select: 1 = rd, 0 = rt
- write_data_select  output  1  write-back source: 1 = memory, 0 = ALU
- alu_select  output  1  ALU operand 2: 1 = sign-extended constant, 0 = rt data
- alu_op  output  2  to ALU control: 0 = add, 1 = sub, 2 = use function code
- halted  output  1  controller stopped
- error  output  1  sticky: illegal opcode or memory timeout
- instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset = 0, asynchronous):
  - State = FETCH.
  - All outputs 0, including instr_count, halted and error.
- State encoding (exported as constants): FETCH = 0, DECODE = 1, EXECUTE = 2, MEMORY = 3, WRITEBACK = 4, HALT = 5.
- Decoded opcodes:
  - R-type 0x00
  - ADDI 0x08
  - LW 0x23
  - SW 0x2B
  - BEQ 0x04
  - J 0x02
  - HALT 0x3F
  - All other values are illegal.
- FETCH:
  - If enable = 0: idle, all strobes 0.
  - Otherwise assert mem_read.
  - On mem_ready = 1 in the same cycle: ir_write = 1, pc_write = 1, pc_src = 0, next state DECODE.
- DECODE: one cycle, no strobes. Next state:
  - HALT: go to HALT.
  - Illegal opcode: go to HALT and set error.
  - J: go to WRITEBACK.
  - Otherwise: go to EXECUTE.
- EXECUTE: one cycle.
  - R-type: alu_op = 2, alu_select = 0, next WRITEBACK.
  - ADDI/LW/SW: alu_op = 0, alu_select = 1.
    - ADDI next WRITEBACK.
    - LW/SW next MEMORY.
  - BEQ: alu_op = 1, alu_select = 0.
    - If zero = 1: pc_write = 1, pc_src = 1.
    - Next WRITEBACK.
- MEMORY:
  - LW holds mem_read; SW holds mem_write.
  - On mem_ready: LW next WRITEBACK; SW next WRITEBACK (retire only, no register write).
- WRITEBACK: one cycle; instr_count increments by 1; next FETCH.
  - R-type: reg_write = 1, reg_dst = 1, write_data_select = 0.
  - ADDI: reg_write = 1, reg_dst = 0, write_data_select = 0.
  - LW: reg_write = 1, reg_dst = 0, write_data_select = 1.
  - J: pc_write = 1, pc_src = 2.
- Instruction latencies (cycles, with mem_ready in the first cycle of each access):
  - R-type 4, ADDI 4, BEQ 4, J 3, SW 5, LW 5.
- Memory timeout:
  - A wait counter resets on entry to FETCH-with-enable or MEMORY.
  - It increments each cycle mem_ready = 0.
  - Reaching MEM_TIMEOUT: go to HALT, set error, drop the request.
  - mem_ready in the same cycle as the terminal count wins (no error).
- HALT:
  - halted = 1, all strobes 0; absorbing.
  - Only reset exits HALT.
  - instr_count does not count the HALT instruction.
- enable = 0 mid-instruction has no effect; the instruction completes and the controller then idles in FETCH.
- mem_ready outside FETCH/MEMORY is ignored.
- Strobes (pc_write, ir_write, mem_*, reg_write) are combinational from state and inputs; state, counters and flags are registered.
- Reset mid-operation aborts immediately; no partial write is permitted after the reset edge.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT)
  - state encoding
  - alu_op encodings
  - pc_src encodings
- alu_control reuses the same alu_op encodings.
- One sub-module: mem_wait_timer, a MEM_TIMEOUT down-counter with clear/expire.

Test Plan:
- R-type after reset:
  - Stimulus: release reset, enable = 1, opcode = 0x00, mem_ready = 1 always.
  - Response: states 0,1,2,4; reg_write = 1 with reg_dst = 1 in cycle 4; instr_count = 1.
- LW with one-cycle data stall:
  - Stimulus: opcode = 0x23, mem_ready = 0 for the first MEMORY cycle.
  - Response: mem_read held 2 cycles; write_data_select = 1, reg_write = 1 in WRITEBACK; total 6 cycles.
- BEQ:
  - Stimulus: zero = 1, then a second BEQ with zero = 0.
  - Response: first gives pc_write = 1 with pc_src = 1 in EXECUTE; second gives no pc_write in EXECUTE; instr_count = 2.
- Illegal opcode:
  - Stimulus: opcode = 0x3E.
  - Response: error = 1, halted = 1 from the cycle after DECODE; strobes stay 0 for 20 cycles.
  - Then opcode = 0x3F after reset: halted = 1, error = 0, instr_count = 0.
- Memory timeout:
  - Stimulus: FETCH with mem_ready = 0 for 15 cycles.
  - Response: HALT, error = 1.
  - Repeat with mem_ready = 1 on the 15th cycle: normal DECODE, no error.
- Asynchronous reset mid-MEMORY:
  - Stimulus: SW with reset pulled low between clock edges.
  - Response: all outputs 0 immediately, state FETCH, no mem_write afterwards.
  - Also cover counter wrap: with CNT_W = 4 and 16 R-type instructions, instr_count returns to 0.
